csr_regfile: RTL and testbench

CSR_REGFILE -- requirements
Module: csr_regfile

---
 rtl/csr_regfile_if.sv | 23 ++
 rtl/csr_regfile.sv | 147 ++++++++++++++
 tb/tb_csr_regfile.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/csr_regfile_if.sv
// CSR register-file bus: ID-stage read port, WB-stage write port and the
// retire pulse that feeds minstret.
interface csr_regfile_if;
  logic [11:0] read_addr;
  logic [31:0] read_data;
  logic        read_illegal;
  logic        write_en;
  logic [11:0] write_addr;
  logic [31:0] write_data;
  logic        instret_inc;

  // Handshake: none. A read is a pure combinational lookup of read_addr.
  // A write is a one-cycle request that commits on the next rising clk
  // while write_en=1; the slave always accepts it.
  modport master (
    output read_addr, write_en, write_addr, write_data, instret_inc,
    input  read_data, read_illegal
  );
  modport slave (
    input  read_addr, write_en, write_addr, write_data, instret_inc,
    output read_data, read_illegal
  );
endinterface

// File: rtl/csr_regfile.sv
// Machine-mode CSR register file with WB->ID write bypass.
// Define CSR_COUNTERS_EN to build the mcycle/minstret 64-bit counters.
module csr_regfile (
  input  logic          clk,
  input  logic          rst,
  csr_regfile_if.slave  bus
);

  localparam logic [3:0] ID_NONE     = 4'd0;
  localparam logic [3:0] ID_MSTATUS  = 4'd1;
  localparam logic [3:0] ID_MISA     = 4'd2;
  localparam logic [3:0] ID_MTVEC    = 4'd3;
  localparam logic [3:0] ID_MSCRATCH = 4'd4;
  localparam logic [3:0] ID_MEPC     = 4'd5;
  localparam logic [3:0] ID_MCAUSE   = 4'd6;
  localparam logic [3:0] ID_MTVAL    = 4'd7;
  localparam logic [3:0] ID_MHARTID  = 4'd8;
`ifdef CSR_COUNTERS_EN
  localparam logic [3:0] ID_MCYCLE    = 4'd9;
  localparam logic [3:0] ID_MCYCLEH   = 4'd10;
  localparam logic [3:0] ID_MINSTRET  = 4'd11;
  localparam logic [3:0] ID_MINSTRETH = 4'd12;
`endif

  localparam logic [31:0] MISA_VALUE = 32'h4000_0100;

  // Shadows decode to the same id as their backing half, so bypass
  // matching covers them for free.
  function automatic logic [3:0] decode(input logic [11:0] addr);
    logic [3:0] id;
    id = ID_NONE;
    case (addr)
      12'h300: id = ID_MSTATUS;
      12'h301: id = ID_MISA;
      12'h305: id = ID_MTVEC;
      12'h340: id = ID_MSCRATCH;
      12'h341: id = ID_MEPC;
      12'h342: id = ID_MCAUSE;
      12'h343: id = ID_MTVAL;
      12'hF14: id = ID_MHARTID;
`ifdef CSR_COUNTERS_EN
      12'hB00, 12'hC00: id = ID_MCYCLE;
      12'hB80, 12'hC80: id = ID_MCYCLEH;
      12'hB02, 12'hC02: id = ID_MINSTRET;
      12'hB82, 12'hC82: id = ID_MINSTRETH;
`endif
      default: id = ID_NONE;
    endcase
    return id;
  endfunction

  function automatic logic [31:0] mask_wdata(input logic [3:0] id, input logic [31:0] d);
    logic [31:0] m;
    m = d;
    case (id)
      ID_MSTATUS:        m = d & 32'h0000_0088;
      ID_MTVEC, ID_MEPC: m = {d[31:2], 2'b00};
      default:           m = d;
    endcase
    return m;
  endfunction

  logic [31:0] mstatus_q, mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q;
  logic [3:0]  rd_id, wr_id;
  logic        wr_hit;
  logic [31:0] wr_value;
  logic [31:0] stored_value;

  assign rd_id    = decode(bus.read_addr);
  assign wr_id    = decode(bus.write_addr);
  assign wr_value = mask_wdata(wr_id, bus.write_data);

  // Addresses 0xC00-0xFFF are the read-only CSR range: this rejects the
  // counter shadows and mhartid; misa is rejected by id.
  assign wr_hit = bus.write_en && (wr_id != ID_NONE) && (wr_id != ID_MISA)
                  && (bus.write_addr[11:10] != 2'b11);

`ifdef CSR_COUNTERS_EN
  logic [63:0] mcycle_q, minstret_q;

  // A write to either half replaces the increment for that cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mcycle_q   <= 64'd0;
      minstret_q <= 64'd0;
    end else begin
      if (wr_hit && wr_id == ID_MCYCLE)       mcycle_q[31:0]  <= bus.write_data;
      else if (wr_hit && wr_id == ID_MCYCLEH) mcycle_q[63:32] <= bus.write_data;
      else                                    mcycle_q        <= mcycle_q + 64'd1;

      if (wr_hit && wr_id == ID_MINSTRET)       minstret_q[31:0]  <= bus.write_data;
      else if (wr_hit && wr_id == ID_MINSTRETH) minstret_q[63:32] <= bus.write_data;
      else if (bus.instret_inc)                 minstret_q        <= minstret_q + 64'd1;
    end
  end
`else
  logic unused_instret_inc;
  assign unused_instret_inc = bus.instret_inc;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mstatus_q  <= 32'd0;
      mtvec_q    <= 32'd0;
      mscratch_q <= 32'd0;
      mepc_q     <= 32'd0;
      mcause_q   <= 32'd0;
      mtval_q    <= 32'd0;
    end else if (wr_hit) begin
      case (wr_id)
        ID_MSTATUS:  mstatus_q  <= wr_value;
        ID_MTVEC:    mtvec_q    <= wr_value;
        ID_MSCRATCH: mscratch_q <= wr_value;
        ID_MEPC:     mepc_q     <= wr_value;
        ID_MCAUSE:   mcause_q   <= wr_value;
        ID_MTVAL:    mtval_q    <= wr_value;
        default: ;
      endcase
    end
  end

  always_comb begin
    stored_value = 32'd0;
    case (rd_id)
      ID_MSTATUS:   stored_value = mstatus_q;
      ID_MISA:      stored_value = MISA_VALUE;
      ID_MTVEC:     stored_value = mtvec_q;
      ID_MSCRATCH:  stored_value = mscratch_q;
      ID_MEPC:      stored_value = mepc_q;
      ID_MCAUSE:    stored_value = mcause_q;
      ID_MTVAL:     stored_value = mtval_q;
`ifdef CSR_COUNTERS_EN
      ID_MCYCLE:    stored_value = mcycle_q[31:0];
      ID_MCYCLEH:   stored_value = mcycle_q[63:32];
      ID_MINSTRET:  stored_value = minstret_q[31:0];
      ID_MINSTRETH: stored_value = minstret_q[63:32];
`endif
      default:      stored_value = 32'd0;
    endcase
  end

  // Bypass only on an exact half match; the other counter half is untouched
  // by the write, so its stored value is already correct.
  assign bus.read_data    = (wr_hit && wr_id == rd_id) ? wr_value : stored_value;
  assign bus.read_illegal = (rd_id == ID_NONE);

endmodule

// File: tb/tb_csr_regfile.sv
// Directed table-driven bench for csr_regfile; counter sequences run only
// when CSR_COUNTERS_EN is defined, otherwise counter addresses must be illegal.
module tb_csr_regfile;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  csr_regfile_if bus ();

  csr_regfile dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] raddr;
    logic        we;
    logic [11:0] waddr;
    logic [31:0] wdata;
    logic [31:0] exp_data;
    logic        exp_ill;
  } vec_t;

  vec_t vecs[19];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] exp_data, input logic exp_ill);
    checks++;
    if (bus.read_data !== exp_data || bus.read_illegal !== exp_ill) begin
      errors++;
      $display("FAIL %s: read_data=%h illegal=%b, expected %h illegal=%b",
               name, bus.read_data, bus.read_illegal, exp_data, exp_ill);
    end
  endtask

  task automatic rd_check(input string name, input logic [11:0] addr,
                          input logic [31:0] exp_data, input logic exp_ill);
    bus.read_addr = addr;
    #1;
    check(name, exp_data, exp_ill);
  endtask

  task automatic set_write(input logic we, input logic [11:0] addr, input logic [31:0] data);
    bus.write_en   = we;
    bus.write_addr = addr;
    bus.write_data = data;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    bus.read_addr   = 12'h000;
    bus.instret_inc = 1'b0;
    set_write(1'b0, 12'h000, 32'd0);

    //            raddr    we    waddr    wdata          exp_data       ill
    vecs[0]  = '{12'h301, 1'b0, 12'h000, 32'h0000_0000, 32'h4000_0100, 1'b0};
    vecs[1]  = '{12'h300, 1'b0, 12'h000, 32'h0000_0000, 32'h0000_0000, 1'b0};
    vecs[2]  = '{12'h999, 1'b0, 12'h000, 32'h0000_0000, 32'h0000_0000, 1'b1};
    vecs[3]  = '{12'h301, 1'b1, 12'h300, 32'hFFFF_FFFF, 32'h4000_0100, 1'b0};
    vecs[4]  = '{12'h300, 1'b0, 12'h000, 32'h0000_0000, 32'h0000_0088, 1'b0};
    vecs[5]  = '{12'h305, 1'b1, 12'h305, 32'h8000_0003, 32'h8000_0000, 1'b0};
    vecs[6]  = '{12'h305, 1'b0, 12'h000, 32'h0000_0000, 32'h8000_0000, 1'b0};
    vecs[7]  = '{12'h340, 1'b1, 12'h340, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0};
    vecs[8]  = '{12'h340, 1'b0, 12'h000, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0};
    vecs[9]  = '{12'hF14, 1'b1, 12'hF14, 32'h0000_0005, 32'h0000_0000, 1'b0};
    vecs[10] = '{12'hF14, 1'b0, 12'h000, 32'h0000_0000, 32'h0000_0000, 1'b0};
    vecs[11] = '{12'h341, 1'b1, 12'h341, 32'h1234_5677, 32'h1234_5674, 1'b0};
    vecs[12] = '{12'h343, 1'b1, 12'h342, 32'hA5A5_A5A5, 32'h0000_0000, 1'b0};
    vecs[13] = '{12'h342, 1'b0, 12'h000, 32'h0000_0000, 32'hA5A5_A5A5, 1'b0};
    vecs[14] = '{12'h343, 1'b1, 12'h343, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0};
    vecs[15] = '{12'h301, 1'b1, 12'h301, 32'h0000_0000, 32'h4000_0100, 1'b0};
    vecs[16] = '{12'h300, 1'b1, 12'h300, 32'h0000_0008, 32'h0000_0008, 1'b0};
    vecs[17] = '{12'h999, 1'b1, 12'h999, 32'h0000_0123, 32'h0000_0000, 1'b1};
    vecs[18] = '{12'h300, 1'b0, 12'h000, 32'h0000_0000, 32'h0000_0008, 1'b0};

    // Values while reset is held.
    step();
    step();
    rd_check("rst_misa", 12'h301, 32'h4000_0100, 1'b0);
    rd_check("rst_mstatus", 12'h300, 32'h0000_0000, 1'b0);
    rd_check("rst_mscratch", 12'h340, 32'h0000_0000, 1'b0);
`ifdef CSR_COUNTERS_EN
    step();
    rd_check("rst_mcycle", 12'hB00, 32'h0000_0000, 1'b0);
    rd_check("rst_minstret", 12'hC02, 32'h0000_0000, 1'b0);
`endif
    rst = 1'b1;
    step();

    for (int i = 0; i < 19; i++) begin
      bus.read_addr = vecs[i].raddr;
      set_write(vecs[i].we, vecs[i].waddr, vecs[i].wdata);
      #1;
      check($sformatf("vec%0d", i), vecs[i].exp_data, vecs[i].exp_ill);
      step();
    end
    set_write(1'b0, 12'h000, 32'd0);

    // Asynchronous reset clears state without waiting for an edge.
    rst = 1'b0;
    rd_check("async_rst_mscratch", 12'h340, 32'h0000_0000, 1'b0);
    rd_check("async_rst_mstatus", 12'h300, 32'h0000_0000, 1'b0);
    rst = 1'b1;
    step();

`ifdef CSR_COUNTERS_EN
    // mcycle carry from bit 31 into bit 32, write beating the increment.
    bus.read_addr = 12'hC00;
    set_write(1'b1, 12'hB00, 32'hFFFF_FFFE);
    #1;
    check("mcycle_bypass_shadow", 32'hFFFF_FFFE, 1'b0);
    step();
    bus.read_addr = 12'hC80;
    set_write(1'b1, 12'hB80, 32'h0000_0000);
    #1;
    check("mcycleh_bypass", 32'h0000_0000, 1'b0);
    step();
    set_write(1'b0, 12'h000, 32'd0);
    rd_check("mcycle_no_inc_on_write", 12'hC00, 32'hFFFF_FFFE, 1'b0);
    step();
    step();
    step();
    rd_check("cycleh_after_carry", 12'hC80, 32'h0000_0001, 1'b0);
    rd_check("cycle_after_carry", 12'hC00, 32'h0000_0001, 1'b0);

    // 64-bit wrap to zero.
    set_write(1'b1, 12'hB00, 32'hFFFF_FFFF);
    step();
    set_write(1'b1, 12'hB80, 32'hFFFF_FFFF);
    step();
    set_write(1'b0, 12'h000, 32'd0);
    rd_check("mcycleh_all_ones", 12'hB80, 32'hFFFF_FFFF, 1'b0);
    step();
    rd_check("mcycle_wrap_lo", 12'hB00, 32'h0000_0000, 1'b0);
    rd_check("mcycle_wrap_hi", 12'hB80, 32'h0000_0000, 1'b0);

    // minstret counts retire pulses only.
    set_write(1'b1, 12'hB02, 32'd0);
    step();
    set_write(1'b1, 12'hB82, 32'd0);
    step();
    set_write(1'b0, 12'h000, 32'd0);
    for (int p = 0; p < 5; p++) begin
      bus.instret_inc = 1'b1;
      step();
      bus.instret_inc = 1'b0;
      step();
      step();
    end
    rd_check("instret_5", 12'hC02, 32'h0000_0005, 1'b0);
    rd_check("instreth_0", 12'hC82, 32'h0000_0000, 1'b0);

    bus.instret_inc = 1'b1;
    set_write(1'b1, 12'hB02, 32'd100);
    step();
    bus.instret_inc = 1'b0;
    set_write(1'b0, 12'h000, 32'd0);
    rd_check("minstret_write_wins", 12'hB02, 32'd100, 1'b0);

    // Mid-sequence reset, then first increment on the first edge after release.
    bus.instret_inc = 1'b1;
    rst = 1'b0;
    rd_check("rst_instret_now", 12'hC02, 32'h0000_0000, 1'b0);
    rd_check("rst_cycle_now", 12'hC00, 32'h0000_0000, 1'b0);
    bus.instret_inc = 1'b0;
    rst = 1'b1;
    step();
    rd_check("first_cycle_after_rst", 12'hC00, 32'h0000_0001, 1'b0);
    rd_check("instret_after_rst", 12'hC02, 32'h0000_0000, 1'b0);
`else
    // Counter addresses are unimplemented in this build.
    bus.instret_inc = 1'b1;
    set_write(1'b1, 12'hB00, 32'h0000_0007);
    rd_check("nocnt_mcycle_wr", 12'hB00, 32'h0000_0000, 1'b1);
    step();
    set_write(1'b0, 12'h000, 32'd0);
    bus.instret_inc = 1'b0;
    rd_check("nocnt_mcycle", 12'hB00, 32'h0000_0000, 1'b1);
    rd_check("nocnt_instret", 12'hC02, 32'h0000_0000, 1'b1);
    rd_check("nocnt_cycleh", 12'hC80, 32'h0000_0000, 1'b1);
    bus.read_addr = 12'h340;
    set_write(1'b1, 12'h340, 32'hDEAD_BEEF);
    #1;
    check("nocnt_mscratch_bypass", 32'hDEAD_BEEF, 1'b0);
    step();
    set_write(1'b0, 12'h000, 32'd0);
    rd_check("nocnt_mscratch", 12'h340, 32'hDEAD_BEEF, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
